inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the NPC core; directly upstream of the instruction decoder. Owns the program counter, issues one 32-bit instruction read at a time to instruction memory over a valid/ready request plus valid response channel, and presents the fetched instruction and its PC to decode over a valid/ready handshake. Accepts redirects (jump, branch, trap, mret) from execute and discards any in-flight or held instruction they make stale.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded by reset.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assertion, active-high.
- redirect_valid  in  1  redirect request from execute; single-cycle pulse.
- redirect_pc  in  64  redirect target; bits [1:0] are forced to 0 internally.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  fetch address; always equals the internal pc.
- imem_resp_valid  in  1  response valid; exactly one response per accepted request, at least 1 cycle after acceptance.
- imem_resp_data  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes the instruction.
- inst  out  32  instruction word to decode.
- inst_pc  out  64  PC of inst.

## Operation
- State machine states: REQ, WAIT, HOLD. Registers: pc[63:0], inst[31:0], inst_pc[63:0], kill (1 bit).
- REQ: imem_req_valid=1 and imem_req_addr=pc.
  - On handshake, go to WAIT; set kill=redirect_valid; if redirect_valid, pc<=redirect_pc.
  - With no handshake and redirect_valid, pc<=redirect_pc and stay in REQ. The address may change only while the request is unaccepted.
- WAIT: imem_req_valid=0.
  - redirect_valid without a response: pc<=redirect_pc and kill<=1. A later redirect overwrites pc again.
  - imem_resp_valid with kill=0 and no same-cycle redirect: inst<=imem_resp_data, inst_pc<=pc, go to HOLD.
  - imem_resp_valid with kill=1 or a same-cycle redirect: drop the response, kill<=0, go to REQ. With a same-cycle redirect, pc<=redirect_pc.
- HOLD: inst_valid=1.
  - redirect_valid: drop the held instruction, pc<=redirect_pc, go to REQ. Redirect has priority over inst_ready.
  - inst_ready with no redirect: pc<=pc+4 (64-bit modulo wrap), go to REQ.
  - Otherwise hold inst and inst_pc stable.
- inst_valid=1 only in HOLD. inst and inst_pc do not change while inst_valid=1.
- pc arithmetic: 64-bit unsigned. 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0. No alignment fault is raised.

## Timing
- Reset values: state=REQ, pc=RESET_PC, kill=0, inst=32'h0000_0013 (nop), inst_pc=RESET_PC. Resulting outputs: imem_req_valid=1, imem_req_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013, inst_pc=RESET_PC.
- Reset mid-operation: state returns to REQ immediately. An outstanding response arriving after reset release is not expected; memory is reset together with this block.
- Latency: request accepted at cycle t, response at t+n (n≥1), inst_valid at t+n+1.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with zero-wait memory and inst_ready held high).
- A redirect takes effect on the next edge. The first request to the target is issued in REQ the cycle after the redirect, or after the killed response when it arrives in WAIT.

## Structure
- Shared package (core-wide): RESET_PC constant, NOP_INST constant 32'h0000_0013, fetch-state enum {REQ, WAIT, HOLD}.
- No sub-module. A single module with one state register and one next-state block.

## Test plan
- Reset, ready-on-request memory, 1-cycle response 32'h0010_0073: imem_req_addr=0x8000_0000, then inst_valid=1 with inst=32'h0010_0073 and inst_pc=0x8000_0000; inst_ready=1 leads to the next request at 0x8000_0004.
- Decode stalls (inst_ready=0) for 5 cycles in HOLD: inst and inst_pc remain stable, no new imem request, and pc advances by exactly 4 after release.
- Redirect to 0x8000_0100 in WAIT, response arrives 3 cycles later: response dropped, inst_valid never rises for it, next request at 0x8000_0100.
- Redirect to 0x8000_0203 in the same cycle as imem_resp_valid: response dropped, next request at 0x8000_0200.
- Redirect in HOLD together with inst_ready=1: held instruction not counted as consumed, next request at the redirect target rather than pc+4.
- imem_req_ready held low 4 cycles with a redirect to 0x8000_0040 in cycle 2: imem_req_addr changes to 0x8000_0040, the handshake occurs at that address, and a single response is expected.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_pkg
//  Description : Core-wide constants and types shared by the fetch stage.
//                RESET_PC  - PC loaded by reset
//                NOP_INST  - instruction presented to decode while nothing
//                            has been fetched yet (addi x0,x0,0)
//                fetch_state_e - fetch sequencer states
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,   // request outstanding on the imem request channel
        WAIT = 2'd1,   // request accepted, waiting for the response
        HOLD = 2'd2    // instruction presented to decode
    } fetch_state_e;

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_if
//  Description : Signal bundle between the fetch stage and its neighbours.
//                Redirect      : redirect_valid / redirect_pc     (from execute)
//                Imem request  : imem_req_valid / imem_req_ready / imem_req_addr
//                Imem response : imem_resp_valid / imem_resp_data
//                Decode        : inst_valid / inst_ready / inst / inst_pc
//                master modport - the fetch stage
//                slave modport  - execute, instruction memory and decode
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;

    logic        redirect_valid;
    logic [63:0] redirect_pc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface : inst_fetch_if
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch stage. Owns the PC, issues one 32-bit
//                instruction read at a time and hands the fetched word with
//                its PC to decode. Redirects from execute discard any stale
//                in-flight or held instruction.
//  Ports       : clk  - core clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - inst_fetch_if.master (redirect, imem, decode)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  wire              clk,
    input  wire              rst,
    inst_fetch_if.master     bus
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [63:0]  inst_pc_q, inst_pc_d;
    logic         kill_q, kill_d;

    // Redirect targets are always word aligned; the low bits are dropped
    // without raising any fault.
    logic [63:0]  redir_pc;
    assign redir_pc = bus.redirect_pc & ~64'h3;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            kill_q    <= kill_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        kill_d    = kill_q;

        case (state_q)
            REQ: begin
                // A redirect while the request is unaccepted simply moves
                // the address. If it coincides with acceptance, the request
                // already carries the old address, so its response is stale.
                if (bus.imem_req_ready) begin
                    state_d = WAIT;
                    kill_d  = bus.redirect_valid;
                end
                if (bus.redirect_valid) begin
                    pc_d = redir_pc;
                end
            end

            WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (kill_q || bus.redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                        if (bus.redirect_valid) begin
                            pc_d = redir_pc;
                        end
                    end else begin
                        // pc still equals the requested address here
                        inst_d    = bus.imem_resp_data;
                        inst_pc_d = pc_q;
                        state_d   = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    pc_d   = redir_pc;
                    kill_d = 1'b1;
                end
            end

            HOLD: begin
                // Redirect wins over consumption: the held instruction is
                // on the wrong path and must not advance the PC.
                if (bus.redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
                end else if (bus.inst_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        bus.imem_req_valid = (state_q == REQ);
        bus.imem_req_addr  = pc_q;
        bus.inst_valid     = (state_q == HOLD);
        bus.inst           = inst_q;
        bus.inst_pc        = inst_pc_q;
    end

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Directed self-checking bench for inst_fetch. The bench
//                plays execute, instruction memory and decode; expected
//                values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [63:0] C_RST_PC = 64'h0000_0000_8000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    inst_fetch_if bus ();

    inst_fetch u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_accept();
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        step();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
    endtask

    task automatic redirect(input logic [63:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
    endtask

    task automatic consume();
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst                 = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 64'h0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.inst_ready      = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_req_valid",  {63'd0, bus.imem_req_valid}, 64'd1);
        check("rst_req_addr",   bus.imem_req_addr, C_RST_PC);
        check("rst_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        check("rst_inst",       {32'd0, bus.inst}, 64'h13);
        check("rst_inst_pc",    bus.inst_pc, C_RST_PC);
        rst = 1'b0;
        step();
        check("post_rst_addr",  bus.imem_req_addr, C_RST_PC);

        // ---------------- basic fetch, zero-wait memory ----------------
        req_accept();
        check("t1_wait_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check("t1_wait_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        respond(32'h0010_0073);
        check("t1_inst_valid", {63'd0, bus.inst_valid}, 64'd1);
        check("t1_inst",       {32'd0, bus.inst}, 64'h0010_0073);
        check("t1_inst_pc",    bus.inst_pc, 64'h8000_0000);
        consume();
        check("t1_next_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        check("t1_next_addr",      bus.imem_req_addr, 64'h8000_0004);
        check("t1_inst_valid_off", {63'd0, bus.inst_valid}, 64'd0);

        // ---------------- decode stall in HOLD ----------------
        req_accept();
        respond(32'h00A0_0093);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_stall_inst_valid", {63'd0, bus.inst_valid}, 64'd1);
            check("t2_stall_inst",       {32'd0, bus.inst}, 64'h00A0_0093);
            check("t2_stall_inst_pc",    bus.inst_pc, 64'h8000_0004);
            check("t2_stall_no_req",     {63'd0, bus.imem_req_valid}, 64'd0);
        end
        consume();
        check("t2_next_addr", bus.imem_req_addr, 64'h8000_0008);

        // ---------------- redirect in WAIT, late response ----------------
        req_accept();
        redirect(64'h8000_0100);
        check("t3_still_wait", {63'd0, bus.imem_req_valid}, 64'd0);
        step();
        check("t3_no_inst_a", {63'd0, bus.inst_valid}, 64'd0);
        step();
        check("t3_no_inst_b", {63'd0, bus.inst_valid}, 64'd0);
        respond(32'hDEAD_BEEF);
        check("t3_dropped",    {63'd0, bus.inst_valid}, 64'd0);
        check("t3_req_valid",  {63'd0, bus.imem_req_valid}, 64'd1);
        check("t3_addr",       bus.imem_req_addr, 64'h8000_0100);

        // ---------------- redirect same cycle as response ----------------
        req_accept();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0203;
        respond(32'hCAFE_F00D);
        bus.redirect_valid = 1'b0;
        check("t4_dropped",   {63'd0, bus.inst_valid}, 64'd0);
        check("t4_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        check("t4_addr",      bus.imem_req_addr, 64'h8000_0200);

        // ---------------- redirect in HOLD with inst_ready ----------------
        req_accept();
        respond(32'h0000_0513);
        check("t5_inst_pc", bus.inst_pc, 64'h8000_0200);
        bus.inst_ready = 1'b1;
        redirect(64'h8000_0300);
        bus.inst_ready = 1'b0;
        check("t5_inst_valid_off", {63'd0, bus.inst_valid}, 64'd0);
        check("t5_addr",           bus.imem_req_addr, 64'h8000_0300);
        req_accept();
        respond(32'h0000_0593);
        check("t5_target_inst_pc", bus.inst_pc, 64'h8000_0300);
        consume();

        // ---------------- redirect while request unaccepted ----------------
        check("t6_addr_c0", bus.imem_req_addr, 64'h8000_0304);
        step();
        check("t6_addr_c1", bus.imem_req_addr, 64'h8000_0304);
        redirect(64'h8000_0040);
        check("t6_addr_c2", bus.imem_req_addr, 64'h8000_0040);
        check("t6_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        step();
        step();
        check("t6_addr_c4", bus.imem_req_addr, 64'h8000_0040);
        req_accept();
        respond(32'h0000_0613);
        check("t6_inst_valid", {63'd0, bus.inst_valid}, 64'd1);
        check("t6_inst_pc",    bus.inst_pc, 64'h8000_0040);
        check("t6_inst",       {32'd0, bus.inst}, 64'h0000_0613);
        consume();
        check("t6_next_addr",  bus.imem_req_addr, 64'h8000_0044);

        // ---------------- 64-bit PC wrap ----------------
        redirect(64'hFFFF_FFFF_FFFF_FFFE);
        check("t7_aligned", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        req_accept();
        respond(32'h0000_0693);
        check("t7_inst_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        consume();
        check("t7_wrap_addr", bus.imem_req_addr, 64'h0);

        // ---------------- asynchronous reset mid-operation ----------------
        req_accept();
        check("t8_in_wait", {63'd0, bus.imem_req_valid}, 64'd0);
        #2 rst = 1'b1;
        #1;
        check("t8_async_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        check("t8_async_addr",      bus.imem_req_addr, C_RST_PC);
        check("t8_async_inst",      {32'd0, bus.inst}, 64'h13);
        step();
        rst = 1'b0;
        step();
        check("t8_post_addr", bus.imem_req_addr, C_RST_PC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_inst_fetch
`default_nettype wire
